pipeline_sequencer: RTL

- Central hazard and sequencing controller for the 5-stage pipeline (IF/ID/EX/MEM/WB, 8 x 3-bit-addressed registers).
- Decides each cycle whether PC and IF/ID advance, whether ID/EX receives a bubble, and whether the front end is flushed.
- Owns the multi-cycle SWAP micro-sequence and exposes the current phase to the ID-stage decoder.
- Keeps saturating stall and flush event counters for bring-up and debug.

---
 rtl/pipeline_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_sequencer.sv
// ----------------------------------------------------------------------------
// pipeline_sequencer
//
// Hazard and sequencing controller for the 5-stage IF/ID/EX/MEM/WB pipeline.
// Each cycle it decides whether the PC and IF/ID advance and whether ID/EX
// receives a bubble. It also decides whether the front end is flushed after
// a taken branch or a jump. It runs the multi-cycle SWAP micro-sequence and
// reports the current micro-op index to the ID decoder. Two saturating
// counters record load-use stalls and flush events for bring-up.
//
// Ports:
//   clock            rising-edge clock
//   reset_n          asynchronous active-low reset
//   id_opcode        opcode of the instruction in ID
//   id_valid         ID holds a real instruction
//   id_rs, id_rt     ID source registers
//   ex_mem_read      EX instruction is a load
//   ex_reg_write     EX instruction writes a register
//   ex_write_reg     EX destination register
//   ex_branch_taken  EX branch resolved taken
//   ex_jump          EX jump
//   pc_write         PC may update
//   ifid_write       IF/ID may load
//   idex_bubble      insert a NOP into ID/EX
//   flush_ifid       clear IF/ID
//   flush_idex       clear ID/EX
//   swap_phase       current swap micro-op index
//   busy             swap sequence in progress
//   stall_count      saturating count of load-use stall cycles
//   flush_count      saturating count of flush events
// ----------------------------------------------------------------------------
module pipeline_sequencer #(
   parameter int              REG_W       = 3,
   parameter int              OP_W        = 4,
   parameter logic [OP_W-1:0] SWAP_OP     = 4'b1001,
   parameter int              SWAP_CYCLES = 3,
   parameter int              CNT_W       = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [OP_W-1:0]   id_opcode,
   input  logic              id_valid,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic              ex_mem_read,
   input  logic              ex_reg_write,
   input  logic [REG_W-1:0]  ex_write_reg,
   input  logic              ex_branch_taken,
   input  logic              ex_jump,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              idex_bubble,
   output logic              flush_ifid,
   output logic              flush_idex,
   output logic [1:0]        swap_phase,
   output logic              busy,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_SWAP = 1'b1
   } state_t;

   localparam logic [1:0]       LAST_PHASE = 2'(SWAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   state_t     state, state_next;
   logic [1:0] phase, phase_next;

   logic flush;
   logic load_use;
   logic swap_in_id;

   // Hazard detection. A flush outranks a load-use stall, so the stall term
   // is masked by the flush. That keeps the stall counter from counting
   // cycles whose ID instruction is being discarded anyway.
   assign flush      = ex_branch_taken | ex_jump;
   assign load_use   = id_valid & ex_mem_read & ex_reg_write &
                       ((ex_write_reg == id_rs) | (ex_write_reg == id_rt)) &
                       ~flush;
   assign swap_in_id = id_valid & (id_opcode == SWAP_OP);

   // State register: FSM state and swap phase. Reset aborts any swap.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_RUN;
         phase <= 2'd0;
      end else begin
         state <= state_next;
         phase <= phase_next;
      end
   end

   // Next-state logic. A stall freezes the sequence. A flush always returns
   // to RUN. A swap moves to phase 1 in SWAP after issuing phase 0 from RUN.
   always_comb begin
      state_next = state;
      phase_next = phase;
      if (flush) begin
         state_next = ST_RUN;
         phase_next = 2'd0;
      end else if (load_use) begin
         state_next = state;
         phase_next = phase;
      end else if (state == ST_RUN) begin
         if (swap_in_id) begin
            state_next = ST_SWAP;
            phase_next = 2'd1;
         end
      end else begin
         if (phase == LAST_PHASE) begin
            state_next = ST_RUN;
            phase_next = 2'd0;
         end else begin
            phase_next = phase + 2'd1;
         end
      end
   end

   // Output logic. Outputs are combinational, so a hazard seen this cycle
   // takes effect this cycle. During reset the pipeline is frozen and only
   // bubbles enter ID/EX. A flush issues no micro-op, so busy and
   // swap_phase read zero while it is active.
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      swap_phase  = 2'd0;
      busy        = 1'b0;
      if (!reset_n) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
      end else if (flush) begin
         flush_ifid  = 1'b1;
         flush_idex  = 1'b1;
      end else if (load_use) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
         busy        = (state == ST_SWAP);
         swap_phase  = phase;
      end else if (state == ST_RUN) begin
         if (swap_in_id) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
         end
      end else begin
         busy       = 1'b1;
         swap_phase = phase;
         if (phase != LAST_PHASE) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
         end
      end
   end

   // Event counters saturate at all-ones so a long stall cannot wrap the
   // count back to a small value.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (load_use && stall_count != CNT_MAX) begin
            stall_count <= stall_count + 1'b1;
         end
         if (flush && flush_count != CNT_MAX) begin
            flush_count <= flush_count + 1'b1;
         end
      end
   end

endmodule
